// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_pkg
// Brief    : Shared MAC types: drain FSM state encoding and requant/saturate.
// Revision : 1.0
// ============================================================================
package mac_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CLEAR   = 2'd1,
      ST_ACCUM   = 2'd2,
      ST_CAPTURE = 2'd3
   } mac_state_t;

   // Wide working width covers any accumulator up to 62 bits plus rounding headroom.
   function automatic logic signed [63:0] requant_sat(
      input logic signed [63:0] acc,
      input logic        [4:0]  shift,
      input int                 owidth
   );
      logic signed [63:0] r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      r = acc;
      if (shift != 5'd0)
         r = r + (64'sd1 <<< (shift - 5'd1));
      r  = r >>> shift;
      hi = (64'sd1 <<< (owidth - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (owidth - 1));
      if (r > hi)
         r = hi;
      else if (r < lo)
         r = lo;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mac_requant.sv
`default_nettype none
// ============================================================================
// Module   : mac_requant
// Brief    : Combinational round-half-up, arithmetic shift and saturate.
// Revision : 1.0
// ============================================================================
module mac_requant
   import mac_pkg::*;
#(
   parameter int AWIDTH = 27,
   parameter int OWIDTH = 8
)(
   input  logic signed [AWIDTH-1:0] mac_result,
   input  logic        [4:0]        shift,
   output logic signed [OWIDTH-1:0] q
);

   logic signed [63:0] w_ext;
   logic signed [63:0] w_q;
   logic               w_unused_hi;

   assign w_ext       = {{(64-AWIDTH){mac_result[AWIDTH-1]}}, mac_result};
   assign w_q         = requant_sat(w_ext, shift, OWIDTH);
   // Upper bits are pure sign extension after saturation.
   assign q           = w_q[OWIDTH-1:0];
   assign w_unused_hi = ^w_q[63:OWIDTH];

endmodule
`default_nettype wire

// File: rtl/mac_drain_requant.sv
`default_nettype none
// ============================================================================
// Module   : mac_drain_requant
// Brief    : Sequences one MAC dot product and drains it through requant.
// Revision : 1.0
// ============================================================================
module mac_drain_requant
   import mac_pkg::*;
#(
   parameter int AWIDTH = 27,
   parameter int OWIDTH = 8,
   parameter int LWIDTH = 10
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic        [LWIDTH-1:0] len,
   input  logic        [4:0]        shift,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic                     mac_acc_en,
   output logic                     mac_clr,
   input  logic signed [AWIDTH-1:0] mac_result,
   output logic signed [OWIDTH-1:0] out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     busy
);

   localparam logic [LWIDTH-1:0] c_ONE = LWIDTH'(1);

   mac_state_t               r_state;
   logic [LWIDTH-1:0]        r_remaining;
   logic [4:0]               r_shift;
   logic                     r_out_valid;
   logic signed [OWIDTH-1:0] r_out_data;
   logic signed [OWIDTH-1:0] w_requant;
   logic                     w_load;

   // Gating with reset keeps clear and accumulate mutually exclusive at all times.
   assign in_ready   = (r_state == ST_ACCUM) && !reset;
   assign mac_acc_en = in_ready && in_valid;
   assign mac_clr    = reset || (r_state == ST_CLEAR);
   assign busy       = (r_state != ST_IDLE) && !reset;
   assign w_load     = (r_state == ST_CAPTURE) && (!r_out_valid || out_ready);
   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;

   mac_requant #(
      .AWIDTH (AWIDTH),
      .OWIDTH (OWIDTH)
   ) u_requant (
      .mac_result (mac_result),
      .shift      (r_shift),
      .q          (w_requant)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_remaining <= '0;
         r_shift     <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_remaining <= len;
                  r_shift     <= shift;
                  r_state     <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               r_state <= (r_remaining == '0) ? ST_CAPTURE : ST_ACCUM;
            end
            ST_ACCUM: begin
               if (mac_acc_en) begin
                  r_remaining <= r_remaining - c_ONE;
                  if (r_remaining == c_ONE)
                     r_state <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (w_load)
                  r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase

         // A new load wins over a concurrent drain so no result is lost.
         if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_requant;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mac_drain_requant.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_drain_requant
// Brief    : Directed bench with a MAC model and an arithmetic result model.
// Revision : 1.0
// ============================================================================
module tb_mac_drain_requant;

   localparam int AW = 27;
   localparam int OW = 8;
   localparam int LW = 10;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 start;
   logic        [LW-1:0] len;
   logic        [4:0]    shift;
   logic                 in_valid;
   logic                 in_ready;
   logic                 mac_acc_en;
   logic                 mac_clr;
   logic signed [AW-1:0] mac_result;
   logic signed [OW-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 busy;

   logic signed [7:0]    a;
   logic signed [7:0]    b;
   logic signed [AW-1:0] acc;

   typedef struct {
      longint model;
      longint lit;
      bit     has_lit;
   } exp_t;

   exp_t expq[$];
   int   va[8];
   int   vb[8];
   int   errors = 0;
   int   checks = 0;
   int   clr_cnt = 0;
   int   acc_cnt = 0;
   bit   prev_hold = 1'b0;
   logic signed [OW-1:0] prev_data;

   always #5 clk = ~clk;

   mac_drain_requant #(.AWIDTH(AW), .OWIDTH(OW), .LWIDTH(LW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .len        (len),
      .shift      (shift),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .mac_acc_en (mac_acc_en),
      .mac_clr    (mac_clr),
      .mac_result (mac_result),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy)
   );

   // External MAC: registered accumulator, result read combinationally.
   always @(posedge clk) begin
      if (mac_clr)
         acc <= '0;
      else if (mac_acc_en)
         acc <= acc + a * b;
   end
   assign mac_result = acc;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Round half toward +inf, floor division, clamp to the output range.
   function automatic longint model_q(input longint s, input int sh);
      longint num, d, q, hi, lo;
      num = s + ((sh > 0) ? (longint'(1) << (sh - 1)) : longint'(0));
      d   = longint'(1) << sh;
      q   = num / d;
      if ((num % d) != 0 && num < 0)
         q = q - 1;
      hi = (longint'(1) << (OW - 1)) - 1;
      lo = -(longint'(1) << (OW - 1));
      if (q > hi) q = hi;
      if (q < lo) q = lo;
      return q;
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         prev_hold = 1'b0;
      end else begin
         check("clr_acc_excl", longint'(mac_clr & mac_acc_en), 0);
         if (prev_hold) begin
            check("hold_valid", longint'(out_valid), 1);
            check("hold_data", longint'(out_data), longint'(prev_data));
         end
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               check("unexpected_out", longint'(out_data), 9999);
            end else begin
               exp_t e;
               e = expq.pop_front();
               check("model_out", longint'(out_data), e.model);
               if (e.has_lit)
                  check("literal_out", longint'(out_data), e.lit);
            end
         end
         prev_hold = out_valid && !out_ready;
         prev_data = out_data;
         if (mac_clr)    clr_cnt++;
         if (mac_acc_en) acc_cnt++;
      end
   end

   task automatic wait_idle();
      int cnt = 0;
      while (busy && cnt < 500) begin
         @(posedge clk); #1;
         cnt++;
      end
      if (cnt >= 500)
         check("idle_timeout", longint'(busy), 0);
   endtask

   // abort_after > 0 stops feeding after that many accepted pairs, with no result expected.
   task automatic do_vec(input int n, input int sh, input bit toggle, input bit mid_start,
                         input bit chk_lat, input longint lit, input int abort_after);
      int     idx = 0;
      int     cyc = 0;
      longint sum = 0;
      bit     acc_ok;
      exp_t   e;
      wait_idle();
      for (int i = 0; i < n; i++)
         sum += longint'(va[i]) * longint'(vb[i]);
      if (abort_after == 0) begin
         e.model   = model_q(sum, sh);
         e.lit     = lit;
         e.has_lit = 1'b1;
         expq.push_back(e);
      end
      start = 1'b1;
      len   = LW'(n);
      shift = 5'(sh);
      @(posedge clk); #1;
      start = 1'b0;
      while (idx < n && cyc < 200) begin
         if (abort_after > 0 && idx == abort_after)
            break;
         in_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
         a        = 8'(va[idx]);
         b        = 8'(vb[idx]);
         start    = mid_start && (cyc == 2);
         len      = mid_start ? LW'(1) : LW'(n);
         @(negedge clk);
         acc_ok = in_valid && in_ready;
         @(posedge clk); #1;
         start = 1'b0;
         if (acc_ok) idx++;
         cyc++;
      end
      in_valid = 1'b0;
      if (cyc >= 200)
         check("accept_timeout", idx, n);
      if (chk_lat) begin
         @(negedge clk);
         check("lat_not_early", longint'(out_valid), 0);
         @(negedge clk);
         check("lat_two_cycles", longint'(out_valid), 1);
      end
   endtask

   task automatic set3(input int a0, input int b0, input int a1, input int b1,
                       input int a2, input int b2);
      va[0] = a0; vb[0] = b0; va[1] = a1; vb[1] = b1; va[2] = a2; vb[2] = b2;
   endtask

   initial begin
      int cnt;
      reset = 1'b1; start = 1'b0; len = '0; shift = '0;
      in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_mac_clr", longint'(mac_clr), 1);
      check("rst_in_ready", longint'(in_ready), 0);
      check("rst_acc_en", longint'(mac_acc_en), 0);
      check("rst_busy", longint'(busy), 0);
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_out_data", longint'(out_data), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_clr", longint'(mac_clr), 0);
      check("post_rst_busy", longint'(busy), 0);

      set3(2, 3, 4, 5, -1, 7);
      do_vec(3, 0, 1'b0, 1'b0, 1'b1, 19, 0);
      do_vec(3, 2, 1'b0, 1'b0, 1'b1, 5, 0);
      set3(-2, 3, -4, 5, 1, 7);
      do_vec(3, 2, 1'b0, 1'b0, 1'b0, -5, 0);
      set3(127, 127, 127, 127, 0, 0);
      do_vec(2, 0, 1'b0, 1'b0, 1'b1, 127, 0);
      set3(-128, 127, -128, 127, 0, 0);
      do_vec(2, 0, 1'b0, 1'b0, 1'b0, -128, 0);

      wait_idle();
      clr_cnt = 0; acc_cnt = 0;
      do_vec(0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
      wait_idle();
      check("len0_clr_cycles", clr_cnt, 1);
      check("len0_no_acc_en", acc_cnt, 0);

      // Gapped input plus an ignored start during accumulation.
      set3(1, 2, 3, -4, 5, 6);
      va[3] = -7; vb[3] = 8;
      wait_idle();
      acc_cnt = 0;
      do_vec(4, 1, 1'b1, 1'b1, 1'b0, -18, 0);
      wait_idle();
      check("toggle_acc_count", acc_cnt, 4);

      // Backpressure: first result held, second stalls in capture.
      wait_idle();
      @(posedge clk); #1;
      out_ready = 1'b0;
      set3(2, 3, 4, 5, -1, 7);
      do_vec(3, 0, 1'b0, 1'b0, 1'b0, 19, 0);
      cnt = 0;
      while (!out_valid && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      check("stall_first_valid", longint'(out_valid), 1);
      repeat (10) @(negedge clk);
      do_vec(3, 2, 1'b0, 1'b0, 1'b0, 5, 0);
      repeat (3) @(negedge clk);
      check("stall_in_capture", longint'(busy), 1);
      check("stall_data_kept", longint'(out_data), 19);
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_idle();
      repeat (3) @(posedge clk);
      #1;

      // Reset mid-operation abandons the product.
      va[0] = 1; vb[0] = 1; va[1] = 2; vb[1] = 2; va[2] = 3; vb[2] = 3; va[3] = 4; vb[3] = 4;
      do_vec(4, 0, 1'b0, 1'b0, 1'b0, 0, 2);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("abort_out_valid", longint'(out_valid), 0);
      check("abort_idle", longint'(busy), 0);
      check("abort_in_ready", longint'(in_ready), 0);
      va[0] = 3; vb[0] = 3;
      do_vec(1, 0, 1'b0, 1'b0, 1'b1, 9, 0);

      cnt = 0;
      while (expq.size() != 0 && cnt < 100) begin
         @(posedge clk); #1;
         cnt++;
      end
      check("all_results_seen", expq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
